// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: machine word and the RAM model's handshake state.
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

endpackage

// File: rtl/memory_control.sv
// Memory-side responder: arbitrates instruction/data requests onto the single-ported RAM
// and returns iwait/dwait handshakes; data wins until a burst cap forces one instruction grant.
module memory_control
  import cpu_types_pkg::*;
#(
  parameter int DBURST_MAX = 4
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     iaddr,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      iwait,
  output logic      dwait,
  output word_t     iload,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate
);

  typedef enum logic [1:0] {
    IDLE,
    DGRANT,
    IGRANT
  } state_t;

  // dcount is only 3 bits wide, so an oversized cap saturates at 7.
  localparam logic [2:0] DBURST_LIM = (DBURST_MAX > 7) ? 3'd7 : 3'(DBURST_MAX);

  state_t     state_q, state_d;
  logic [2:0] dcount_q, dcount_d;
  logic       dreq;
  logic       dburst_ok;
  logic       ram_access;

  assign dreq       = dREN | dWEN;
  assign dburst_ok  = dcount_q < DBURST_LIM;
  assign ram_access = (ramstate == ACCESS);

  assign iload = ramload;
  assign dload = ramload;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      dcount_q <= '0;
    end else begin
      state_q  <= state_d;
      dcount_q <= dcount_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    dcount_d = dcount_q;
    iwait    = 1'b1;
    dwait    = 1'b1;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;

    case (state_q)
      IDLE: begin
        if (!iREN) begin
          dcount_d = '0;
        end
        if (dreq && (!iREN || dburst_ok)) begin
          state_d = DGRANT;
        end else if (iREN) begin
          state_d  = IGRANT;
          dcount_d = '0;
        end
      end

      DGRANT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        // BUSY/ERROR/FREE simply hold the grant; only a completed access counts toward the burst.
        if (!dreq) begin
          state_d = IDLE;
        end else if (ram_access) begin
          dwait   = 1'b0;
          state_d = IDLE;
          if (iREN && dburst_ok) begin
            dcount_d = dcount_q + 3'd1;
          end
        end
      end

      IGRANT: begin
        ramaddr = iaddr;
        ramREN  = iREN;
        if (!iREN) begin
          state_d = IDLE;
        end else if (ram_access) begin
          iwait   = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_memory_control.sv
// Directed bench for memory_control: completions are predicted into a scoreboard and
// checked by a negedge monitor; cycle-level expectations are checked inline.
module tb_memory_control;
  import cpu_types_pkg::*;

  logic      CLK = 1'b0;
  logic      nRST;
  logic      iREN, dREN, dWEN;
  word_t     iaddr, daddr, dstore;
  logic      iwait, dwait;
  word_t     iload, dload;
  logic      ramREN, ramWEN;
  word_t     ramaddr, ramstore, ramload;
  ramstate_t ramstate;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic  instr;
    word_t addr;
    word_t data;
  } exp_t;

  exp_t sb[$];

  always #5 CLK = ~CLK;

  memory_control #(.DBURST_MAX(4)) dut (
    .CLK     (CLK),
    .nRST    (nRST),
    .iREN    (iREN),
    .dREN    (dREN),
    .dWEN    (dWEN),
    .iaddr   (iaddr),
    .daddr   (daddr),
    .dstore  (dstore),
    .iwait   (iwait),
    .dwait   (dwait),
    .iload   (iload),
    .dload   (dload),
    .ramREN  (ramREN),
    .ramWEN  (ramWEN),
    .ramaddr (ramaddr),
    .ramstore(ramstore),
    .ramload (ramload),
    .ramstate(ramstate)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    @(negedge CLK);
  endtask

  task automatic push(input logic instr, input word_t a, input word_t d);
    exp_t e;
    e.instr = instr;
    e.addr  = a;
    e.data  = d;
    sb.push_back(e);
  endtask

  // Completion monitor plus per-cycle exclusivity invariants
  always @(negedge CLK) begin
    if (nRST === 1'b1) begin
      chk("wait_excl", 32'(iwait | dwait), 32'd1);
      chk("en_excl", 32'(ramREN & ramWEN), 32'd0);
      if (iwait === 1'b0 || dwait === 1'b0) begin
        chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("done_kind", 32'({iwait, dwait}), e.instr ? 32'd1 : 32'd2);
          chk("done_addr", ramaddr, e.addr);
          chk("done_load", e.instr ? iload : dload, e.data);
        end
      end
    end
  end

  initial begin
    nRST     = 1'b0;
    iREN     = 1'b0;
    dREN     = 1'b0;
    dWEN     = 1'b0;
    iaddr    = '0;
    daddr    = '0;
    dstore   = '0;
    ramload  = 32'h1357_9BDF;
    ramstate = FREE;

    // Reset values
    #3;
    chk("rst_iwait", iwait, 1);
    chk("rst_dwait", dwait, 1);
    chk("rst_ramREN", ramREN, 0);
    chk("rst_ramWEN", ramWEN, 0);
    chk("rst_ramaddr", ramaddr, 0);
    chk("rst_ramstore", ramstore, 0);
    chk("rst_iload", iload, 32'h1357_9BDF);
    chk("rst_dload", dload, 32'h1357_9BDF);
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;

    // Instruction read with two BUSY cycles
    tick();
    iREN = 1'b1; iaddr = 32'h40; ramstate = BUSY;
    settle();
    chk("i_c0_ramREN", ramREN, 0);
    chk("i_c0_iwait", iwait, 1);
    tick();
    settle();
    chk("i_c1_ramaddr", ramaddr, 32'h40);
    chk("i_c1_ramREN", ramREN, 1);
    chk("i_c1_iwait", iwait, 1);
    tick();
    settle();
    chk("i_c2_iwait", iwait, 1);
    chk("i_c2_ramaddr", ramaddr, 32'h40);
    tick();
    ramstate = ACCESS; ramload = 32'h8C01_0004;
    push(1'b1, 32'h40, 32'h8C01_0004);
    settle();
    chk("i_c3_iwait", iwait, 0);
    chk("i_c3_iload", iload, 32'h8C01_0004);
    chk("i_c3_dwait", dwait, 1);
    tick();
    iREN = 1'b0; ramstate = FREE;
    settle();
    chk("i_c4_iwait", iwait, 1);
    chk("i_c4_ramREN", ramREN, 0);

    // Data write, immediate ACCESS
    tick();
    dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEAD_BEEF; ramstate = ACCESS; ramload = '0;
    settle();
    chk("w_c0_dwait", dwait, 1);
    chk("w_c0_ramWEN", ramWEN, 0);
    tick();
    push(1'b0, 32'h100, 32'h0);
    settle();
    chk("w_c1_ramWEN", ramWEN, 1);
    chk("w_c1_ramREN", ramREN, 0);
    chk("w_c1_ramstore", ramstore, 32'hDEAD_BEEF);
    chk("w_c1_ramaddr", ramaddr, 32'h100);
    chk("w_c1_dwait", dwait, 0);
    chk("w_c1_iwait", iwait, 1);
    tick();
    dWEN = 1'b0; ramstate = FREE;
    settle();
    chk("w_c2_dwait", dwait, 1);
    chk("w_c2_ramWEN", ramWEN, 0);

    // Contention: four data grants, one forced instruction grant, then data again
    tick();
    iREN = 1'b1; dREN = 1'b1; dWEN = 1'b0;
    iaddr = 32'h80; daddr = 32'h200; ramstate = ACCESS;
    for (int k = 0; k < 12; k++) begin
      logic exp_d, exp_i;
      if (k > 0) tick();
      exp_d   = (k == 1) || (k == 3) || (k == 5) || (k == 7) || (k == 11);
      exp_i   = (k == 9);
      ramload = 32'hA000_0000 + 32'(k);
      if (exp_d) push(1'b0, 32'h200, ramload);
      if (exp_i) push(1'b1, 32'h80, ramload);
      settle();
      chk($sformatf("cont%0d_dwait", k), dwait, !exp_d);
      chk($sformatf("cont%0d_iwait", k), iwait, !exp_i);
    end
    tick();
    iREN = 1'b0; dREN = 1'b0; ramstate = FREE;
    settle();
    chk("cont_end_iwait", iwait, 1);
    chk("cont_end_dwait", dwait, 1);

    // Read and write both asserted: write wins
    tick();
    dREN = 1'b1; dWEN = 1'b1; daddr = 32'h300; dstore = 32'h1234_5678; ramstate = BUSY;
    settle();
    chk("rw_c0_dwait", dwait, 1);
    tick();
    settle();
    chk("rw_c1_ramWEN", ramWEN, 1);
    chk("rw_c1_ramREN", ramREN, 0);
    chk("rw_c1_dwait", dwait, 1);
    tick();
    ramstate = ACCESS; ramload = 32'h0BAD_F00D;
    push(1'b0, 32'h300, 32'h0BAD_F00D);
    settle();
    chk("rw_c2_dwait", dwait, 0);
    chk("rw_c2_ramstore", ramstore, 32'h1234_5678);
    tick();
    dREN = 1'b0; dWEN = 1'b0; ramstate = FREE;
    settle();
    chk("rw_c3_dwait", dwait, 1);

    // Request withdrawn while BUSY
    tick();
    dREN = 1'b1; daddr = 32'h400; ramstate = BUSY;
    settle();
    chk("wd_c0_ramREN", ramREN, 0);
    tick();
    settle();
    chk("wd_c1_ramREN", ramREN, 1);
    chk("wd_c1_ramaddr", ramaddr, 32'h400);
    tick();
    dREN = 1'b0;
    settle();
    chk("wd_c2_dwait", dwait, 1);
    chk("wd_c2_ramREN", ramREN, 0);
    tick();
    settle();
    chk("wd_c3_ramaddr", ramaddr, 0);
    chk("wd_c3_dwait", dwait, 1);
    ramstate = FREE;

    // Reset asserted mid-grant, then a clean instruction read
    tick();
    iREN = 1'b1; iaddr = 32'h500; ramstate = BUSY;
    settle();
    chk("rm_c0_ramREN", ramREN, 0);
    tick();
    settle();
    chk("rm_c1_ramREN", ramREN, 1);
    #2 nRST = 1'b0;
    #1;
    chk("rm_async_ramREN", ramREN, 0);
    chk("rm_async_iwait", iwait, 1);
    chk("rm_async_ramaddr", ramaddr, 0);
    tick();
    tick();
    nRST = 1'b1;
    settle();
    chk("rm_rel_iwait", iwait, 1);
    chk("rm_rel_ramREN", ramREN, 0);
    tick();
    ramstate = ACCESS; ramload = 32'h55AA_55AA;
    push(1'b1, 32'h500, 32'h55AA_55AA);
    settle();
    chk("rm_done_iwait", iwait, 0);
    chk("rm_done_ramaddr", ramaddr, 32'h500);
    tick();
    iREN = 1'b0; ramstate = FREE;
    settle();
    chk("rm_end_iwait", iwait, 1);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
